wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Bridges a simple valid/ready command stream (from a debug link or sequencer) onto a
//  classic single-transfer Wishbone master bus. It issues one Wishbone cycle per command,
//  waits for ack_i or a timeout, and returns read data and status on a valid/ready
//  response stream. It sits directly upstream of Wishbone slaves such as wb_port.
// PARAMETERS
//  ADDR_WIDTH      32           address width of cmd_adr / adr_o
//  DATA_WIDTH      32           data bus width
//  SELECT_WIDTH    DATA_WIDTH/8 byte-lane select width
//  TIMEOUT_CYCLES  16           bus cycles to wait for ack_i before abort; 0 = wait forever
// PORTS
//  clk          in   1             clock, all logic on posedge
//  rst_n        in   1             asynchronous active-low reset
//  cmd_valid    in   1             command present
//  cmd_ready    out  1             command accepted when valid&ready at posedge
//  cmd_we       in   1             1 = write, 0 = read
//  cmd_adr      in   ADDR_WIDTH    target address
//  cmd_dat      in   DATA_WIDTH    write data
//  cmd_sel      in   SELECT_WIDTH  byte-lane enables
//  rsp_valid    out  1             response present
//  rsp_ready    in   1             response consumed when valid&ready at posedge
//  rsp_dat      out  DATA_WIDTH    dat_i captured at ack; 0 on timeout
//  rsp_timeout  out  1             1 = cycle aborted without ack
//  adr_o        out  ADDR_WIDTH    Wishbone address
//  dat_o        out  DATA_WIDTH    Wishbone write data
//  dat_i        in   DATA_WIDTH    Wishbone read data
//  we_o         out  1             Wishbone write enable
//  sel_o        out  SELECT_WIDTH  Wishbone byte select
//  stb_o        out  1             Wishbone strobe
//  cyc_o        out  1             Wishbone cycle
//  ack_i        in   1             Wishbone acknowledge (combinational ack permitted)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every registered output is 0 (stb_o, cyc_o,
//    we_o, adr_o, dat_o, sel_o, rsp_valid, rsp_dat, rsp_timeout, timeout counter).
//    Reset mid-cycle drops cyc_o/stb_o immediately; the command is lost and no response
//    is produced.
//  - FSM: IDLE -> BUS -> RESP -> IDLE.
//    IDLE: cmd_ready=1 (decoded from state only, never from cmd_valid). On accept, latch
//      cmd_* into adr_o/dat_o/we_o/sel_o, set cyc_o=stb_o=1, clear the counter, go to BUS.
//    BUS: cmd_ready=0. At each posedge with ack_i=1: rsp_dat<=dat_i, rsp_timeout<=0,
//      cyc_o=stb_o<=0, rsp_valid<=1, go to RESP. Otherwise the counter increments.
//      When the counter reaches TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES!=0):
//      rsp_dat<=0, rsp_timeout<=1, cyc_o=stb_o<=0, rsp_valid<=1, go to RESP.
//      If ack_i and the timeout land on the same edge, the ack wins.
//    RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready, rsp_valid<=0 and
//      go to IDLE.
//  - stb_o/cyc_o are high for exactly the cycles in BUS. They deassert on the edge that
//    samples ack_i, so a combinational-ack slave sees exactly one strobed cycle per
//    command (no double writes).
//  - rsp_dat is captured on writes too (slave read-back value).
//  - adr_o/dat_o/we_o/sel_o hold their last values after the cycle ends.
//  - Latency with a zero-wait slave: command accepted at edge E0; stb_o high during
//    E0..E1; rsp_valid high after E1. Next cmd_ready one cycle after the response is taken.
//    Maximum throughput: one command per 3 cycles.
//  - Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and
//    never wraps.
// STRUCTURE
//  - Shared package wb_pkg: FSM state encoding (IDLE/BUS/RESP, 2 bits) and Wishbone
//    sel/width helper constants; reused by other bus masters.
//  - Single flat module; no natural sub-module. The timeout counter is inline.
// TESTING
//  - Write adr=0 dat=32'hDEADBEEF sel=4'hF into wb_port -> port out=32'hDEADBEEF;
//    rsp_valid 2 cycles after accept; rsp_timeout=0.
//  - Then write sel=4'b0010 dat=32'h00005500 -> out=32'hDEAD55EF; exactly one stb_o
//    cycle observed.
//  - Read (we=0) -> rsp_dat=32'hDEAD55EF; port out unchanged.
//  - ack_i tied 0, TIMEOUT_CYCLES=16 -> stb_o high exactly 16 cycles; rsp_timeout=1;
//    rsp_dat=0.
//  - rsp_ready=0 for 5 cycles with cmd_valid held -> rsp_* stable; cmd_ready=0;
//    no new bus cycle. Releasing rsp_ready lets the second command proceed.
//  - rst_n pulsed low while in BUS -> cyc_o/stb_o fall without waiting for clk;
//    rsp_valid=0; cmd_ready=1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone master FSM encoding and bus-width helpers
package wb_pkg;
    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUS  = 2'd1,
        WB_RESP = 2'd2
    } wb_state_e;
    localparam int WB_BYTE_WIDTH = 8;
    function automatic int wb_sel_width(input int data_width);
        return data_width / WB_BYTE_WIDTH;
    endfunction
endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command stream to single-transfer Wishbone master bridge
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = wb_sel_width(DATA_WIDTH),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    input  logic                    ack_i
);
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    wb_state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic accept, ack_hit, to_hit, rsp_take;
    always_comb begin
        cmd_ready = (state_q == WB_IDLE);
        accept    = cmd_ready && cmd_valid;
        ack_hit   = (state_q == WB_BUS) && ack_i;
        // ack on the timeout edge still counts as a successful transfer
        to_hit    = (state_q == WB_BUS) && !ack_i && (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
        rsp_take  = (state_q == WB_RESP) && rsp_valid && rsp_ready;
        state_d   = accept ? WB_BUS :
                    (ack_hit || to_hit) ? WB_RESP :
                    rsp_take ? WB_IDLE : state_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WB_IDLE;
            cnt         <= '0;
            adr_o       <= '0;
            dat_o       <= '0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            stb_o       <= 1'b0;
            cyc_o       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                adr_o <= cmd_adr;
                dat_o <= cmd_dat;
                we_o  <= cmd_we;
                sel_o <= cmd_sel;
                stb_o <= 1'b1;
                cyc_o <= 1'b1;
                cnt   <= '0;
            end else if (ack_hit || to_hit) begin
                stb_o       <= 1'b0;
                cyc_o       <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_dat     <= ack_i ? dat_i : '0;
                rsp_timeout <= !ack_i;
            end else if (state_q == WB_BUS) begin
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end else if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
